bitty_control_unit: RTL and testbench
=====================================

BITTY_CONTROL_UNIT -- requirements
Module: bitty_control_unit

Interface
REQ-001 Parameter NUM_REGS, default 8, is the register-file depth; it SHALL be a power of two, minimum 2.
REQ-002 Parameter INST_W, default 16, is the instruction width; it SHALL be at least 2*IDX_W+6, where IDX_W=$clog2(NUM_REGS).
REQ-003 Parameter DATA_W, default 16, is the datapath width; it SHALL be at least IMM_W, where IMM_W=INST_W-IDX_W-6.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; 0 sampled at a clk edge resets the block.
REQ-006 inst  in  INST_W  instruction word, sampled only on handshake.
REQ-007 inst_valid  in  1  instruction offered.
REQ-008 inst_ready  out  1  block can accept an instruction.
REQ-009 sel  out  4  ALU operation select.
REQ-010 mode  out  1  ALU mode bit.
REQ-011 mux_sel  out  IDX_W+1  bus source: {0,idx} selects register idx; value NUM_REGS selects the immediate.
REQ-012 reg_enable  out  NUM_REGS  one-hot register write enable.
REQ-013 S_enable  out  1  load operand A (source) register.
REQ-014 C_enable  out  1  load operand B / result register.
REQ-015 imm  out  DATA_W  zero-extended immediate.
REQ-016 done  out  1  one-cycle pulse marking the writeback cycle.

Function
REQ-017 Fields SHALL be: rx=inst[INST_W-1 -: IDX_W]; ry=inst[INST_W-1-IDX_W -: IDX_W]; imm field=inst[INST_W-1-IDX_W:6]; sel=inst[5:2]; mode=inst[1]; fmt=inst[0] (0 register form, 1 immediate form).
REQ-018 Handshake SHALL occur at a clk edge where inst_valid && inst_ready; inst SHALL be latched into an internal register at that edge.
REQ-019 States SHALL be IDLE, LOAD_A, LOAD_B, WB; all outputs are Moore, decoded from state and the latched instruction.
REQ-020 inst_ready SHALL be 1 in IDLE and WB, and 0 in LOAD_A and LOAD_B.
REQ-021 Transitions: IDLE->LOAD_A on handshake, else hold; LOAD_A->LOAD_B; LOAD_B->WB; WB->LOAD_A on handshake, else IDLE.
REQ-022 LOAD_A: mux_sel={0,rx}, S_enable=1; all other enables 0.
REQ-023 LOAD_B: mux_sel={0,ry} for register form, or NUM_REGS for immediate form; C_enable=1; all other enables 0.
REQ-024 WB: reg_enable has only bit rx set; done=1; S_enable=C_enable=0; mux_sel=0.
REQ-025 In IDLE, mux_sel, reg_enable, S_enable, C_enable and done SHALL all be 0.
REQ-026 sel, mode and imm SHALL be driven from the latched instruction, so they stay stable from LOAD_A until the next handshake.
REQ-027 Latency: handshake at edge T gives LOAD_A in cycle T+1 and WB/done in cycle T+3; back-to-back throughput is one instruction per 3 cycles.
REQ-028 inst_valid and inst changes outside a handshake SHALL have no effect.

Reset
REQ-029 While reset=0 at an edge, the block SHALL go to IDLE and clear the latched instruction, so sel, mode, mux_sel, reg_enable, S_enable, C_enable, done and imm are all 0.
REQ-030 inst_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 A reset in any state, including mid-instruction, SHALL abort the instruction with no further enables or done.

Configuration
REQ-032 Macro BITTY_IMM_EN defined: the immediate form operates as in REQ-015, REQ-017 and REQ-023.
REQ-033 Macro BITTY_IMM_EN undefined: fmt is ignored and every instruction is register form; imm is tied to 0; mux_sel MSB is always 0.

Structure
REQ-034 Package bitty_pkg SHALL hold the state enum (IDLE, LOAD_A, LOAD_B, WB), the fmt encodings and the field-offset constants.
REQ-035 Sub-module bitty_inst_decode (combinational field extraction and one-hot rx decode) SHALL be instantiated once.

Verification
REQ-036 Reset: hold reset=0 for 3 cycles, then release -> all outputs 0 and inst_ready=1.
REQ-037 Register form: inst=16'h2C0A, one-cycle handshake ->
- T+1: mux_sel=1, S_enable=1.
- T+2: mux_sel=3, C_enable=1.
- T+3: reg_enable=8'b0000_0010, done=1.
- sel=2 and mode=1 throughout.
REQ-038 Immediate form (BITTY_IMM_EN): inst=16'h5541 ->
- T+2: mux_sel=4'b1000, imm=16'h0055, C_enable=1.
- T+3: reg_enable=8'b0000_0100.
REQ-039 Back-to-back: inst_valid held high with two instructions -> second handshake occurs in WB; LOAD_A follows immediately; two done pulses exactly 3 cycles apart.
REQ-040 Mid-operation reset: reset=0 during LOAD_B -> next cycle IDLE; no reg_enable or done pulse for the aborted instruction.
REQ-041 Parameter sweep NUM_REGS=16, INST_W=20: rx=4'hF -> reg_enable has bit 15 set in WB; an immediate-form instruction drives mux_sel=5'h10 in LOAD_B.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared types and field layout for the Bitty control unit.
// The immediate instruction form is enabled by defining BITTY_IMM_EN.
package bitty_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic FMT_REG = 1'b0;
  localparam logic FMT_IMM = 1'b1;

  // Low-order fields sit below the rx/ry/immediate fields at fixed offsets.
  localparam int FMT_BIT  = 0;
  localparam int MODE_BIT = 1;
  localparam int SEL_LSB  = 2;
  localparam int SEL_W    = 4;
  localparam int IMM_LSB  = 6;

endpackage

// File: rtl/bitty_inst_decode.sv
// Combinational field extraction and one-hot destination decode for a latched instruction.
// BITTY_IMM_EN selects whether the fmt bit and the immediate field are honoured.
module bitty_inst_decode
  import bitty_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int INST_W   = 16,
  parameter int DATA_W   = 16,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic [INST_W-1:0]   inst,
  output logic [IDX_W-1:0]    rx,
  output logic [IDX_W-1:0]    ry,
  output logic [SEL_W-1:0]    sel,
  output logic                mode,
  output logic                fmt_imm,
  output logic [DATA_W-1:0]   imm,
  output logic [NUM_REGS-1:0] rx_onehot
);

  localparam int IMM_W = INST_W - IDX_W - IMM_LSB;

  logic [IMM_W-1:0] imm_field;

  // ry occupies the top of the immediate field; both views are taken from the same bits.
  assign rx        = inst[INST_W-1 -: IDX_W];
  assign ry        = inst[INST_W-1-IDX_W -: IDX_W];
  assign imm_field = inst[INST_W-1-IDX_W : IMM_LSB];
  assign sel       = inst[SEL_LSB +: SEL_W];
  assign mode      = inst[MODE_BIT];

`ifdef BITTY_IMM_EN
  assign fmt_imm = (inst[FMT_BIT] == FMT_IMM);
  assign imm     = DATA_W'(imm_field);
`else
  logic unused_imm_bits;
  assign unused_imm_bits = ^{imm_field, inst[FMT_BIT]};
  assign fmt_imm         = 1'b0;
  assign imm             = '0;
`endif

  always_comb begin
    rx_onehot     = '0;
    rx_onehot[rx] = 1'b1;
  end

endmodule

// File: rtl/bitty_control_unit.sv
// Bitty control unit: accepts one instruction per handshake and sequences LOAD_A, LOAD_B, WB.
// Define BITTY_IMM_EN to enable the immediate instruction form.
module bitty_control_unit
  import bitty_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int INST_W   = 16,
  parameter int DATA_W   = 16,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INST_W-1:0]   inst,
  input  logic                inst_valid,
  output logic                inst_ready,
  output logic [3:0]          sel,
  output logic                mode,
  output logic [IDX_W:0]      mux_sel,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                S_enable,
  output logic                C_enable,
  output logic [DATA_W-1:0]   imm,
  output logic                done
);

  localparam logic [IDX_W:0] MUX_IMM = (IDX_W+1)'(NUM_REGS);

  state_t                state, state_nxt;
  logic [INST_W-1:0]     inst_q;
  logic                  hs;
  logic [IDX_W-1:0]      rx, ry;
  logic                  fmt_imm;
  logic [NUM_REGS-1:0]   rx_onehot;

  assign inst_ready = (state == IDLE) || (state == WB);
  assign hs         = inst_valid && inst_ready;

  // State and instruction latch; reset also clears the latch so decoded outputs read 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      inst_q <= '0;
    end else begin
      state <= state_nxt;
      if (hs) inst_q <= inst;
    end
  end

  bitty_inst_decode #(
    .NUM_REGS (NUM_REGS),
    .INST_W   (INST_W),
    .DATA_W   (DATA_W)
  ) u_decode (
    .inst      (inst_q),
    .rx        (rx),
    .ry        (ry),
    .sel       (sel),
    .mode      (mode),
    .fmt_imm   (fmt_imm),
    .imm       (imm),
    .rx_onehot (rx_onehot)
  );

  // Next state and Moore enables.
  always_comb begin
    state_nxt  = state;
    mux_sel    = '0;
    reg_enable = '0;
    S_enable   = 1'b0;
    C_enable   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (inst_valid) state_nxt = LOAD_A;
      end
      LOAD_A: begin
        mux_sel   = {1'b0, rx};
        S_enable  = 1'b1;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        mux_sel   = fmt_imm ? MUX_IMM : {1'b0, ry};
        C_enable  = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        reg_enable = rx_onehot;
        done       = 1'b1;
        state_nxt  = inst_valid ? LOAD_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitty_control_unit.sv
// Directed bench for bitty_control_unit: default 8x16 instance plus a 16-register, 20-bit instance.
module tb_bitty_control_unit;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  sel;
  logic        mode;
  logic [3:0]  mux_sel;
  logic [7:0]  reg_enable;
  logic        S_enable, C_enable, done;
  logic [15:0] imm;

  logic [19:0] inst16;
  logic        inst_valid16;
  logic        inst_ready16;
  logic [3:0]  sel16;
  logic        mode16;
  logic [4:0]  mux_sel16;
  logic [15:0] reg_enable16;
  logic        S_enable16, C_enable16, done16;
  logic [15:0] imm16;

  int checks = 0;
  int errors = 0;

`ifdef BITTY_IMM_EN
  localparam logic [3:0]  EXP_MUX_5541 = 4'h8;
  localparam logic [15:0] EXP_IMM_5541 = 16'h0055;
  localparam logic [4:0]  EXP_MUX16    = 5'h10;
  localparam logic [15:0] EXP_IMM16    = 16'h0080;
`else
  localparam logic [3:0]  EXP_MUX_5541 = 4'h5;
  localparam logic [15:0] EXP_IMM_5541 = 16'h0000;
  localparam logic [4:0]  EXP_MUX16    = 5'h02;
  localparam logic [15:0] EXP_IMM16    = 16'h0000;
`endif

  always #5 clk = ~clk;

  bitty_control_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .sel        (sel),
    .mode       (mode),
    .mux_sel    (mux_sel),
    .reg_enable (reg_enable),
    .S_enable   (S_enable),
    .C_enable   (C_enable),
    .imm        (imm),
    .done       (done)
  );

  bitty_control_unit #(.NUM_REGS(16), .INST_W(20), .DATA_W(16)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst16),
    .inst_valid (inst_valid16),
    .inst_ready (inst_ready16),
    .sel        (sel16),
    .mode       (mode16),
    .mux_sel    (mux_sel16),
    .reg_enable (reg_enable16),
    .S_enable   (S_enable16),
    .C_enable   (C_enable16),
    .imm        (imm16),
    .done       (done16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic rdy, input logic [3:0] mux,
                            input logic [7:0] ren, input logic s, input logic c, input logic d);
    check({tag, ".ready"}, 32'(inst_ready), 32'(rdy));
    check({tag, ".mux_sel"}, 32'(mux_sel), 32'(mux));
    check({tag, ".reg_enable"}, 32'(reg_enable), 32'(ren));
    check({tag, ".S_enable"}, 32'(S_enable), 32'(s));
    check({tag, ".C_enable"}, 32'(C_enable), 32'(c));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic expect_fields(input string tag, input logic [3:0] s, input logic m, input logic [15:0] i);
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".mode"}, 32'(mode), 32'(m));
    check({tag, ".imm"}, 32'(imm), 32'(i));
  endtask

  initial begin
    reset        = 1'b0;
    inst         = 16'h0;
    inst_valid   = 1'b0;
    inst16       = 20'h0;
    inst_valid16 = 1'b0;

    // Reset held for three edges, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    expect_ctl("rst", 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_fields("rst", 4'h0, 1'b0, 16'h0);
    check("rst16.ready", 32'(inst_ready16), 32'd1);
    check("rst16.reg_enable", 32'(reg_enable16), 32'h0);
    check("rst16.mux_sel", 32'(mux_sel16), 32'h0);

    // Register form 16'h2C0A: rx=1 ry=3 sel=2 mode=1.
    inst = 16'h2C0A; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0; inst = 16'hFFFF;
    expect_ctl("reg.T1", 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0);
    expect_fields("reg.T1", 4'h2, 1'b1, 16'h0);
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    expect_ctl("reg.T2", 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_fields("reg.T2", 4'h2, 1'b1, 16'h0);
    @(negedge clk);
    expect_ctl("reg.T3", 1'b1, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0 | 1'b1);
    expect_fields("reg.T3", 4'h2, 1'b1, 16'h0);
    @(negedge clk);
    expect_ctl("reg.T4", 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_fields("reg.T4", 4'h2, 1'b1, 16'h0);

    // Immediate form 16'h5541: rx=2, imm=0x55, sel=0, mode=0.
    inst = 16'h5541; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    expect_ctl("imm.T1", 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_ctl("imm.T2", 1'b0, EXP_MUX_5541, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_fields("imm.T2", 4'h0, 1'b0, EXP_IMM_5541);
    @(negedge clk);
    expect_ctl("imm.T3", 1'b1, 4'h0, 8'h04, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // Back-to-back: valid held high; second instruction 16'hE40C (rx=7 ry=1 sel=3).
    inst = 16'h2C0A; inst_valid = 1'b1;
    @(negedge clk);
    inst = 16'hE40C;
    expect_ctl("b2b.T1", 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_ctl("b2b.T2", 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_fields("b2b.T2", 4'h2, 1'b1, 16'h0);
    @(negedge clk);
    expect_ctl("b2b.T3", 1'b1, 4'h0, 8'h02, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    inst_valid = 1'b0;
    expect_ctl("b2b.T4", 1'b0, 4'h7, 8'h00, 1'b1, 1'b0, 1'b0);
    expect_fields("b2b.T4", 4'h3, 1'b0, 16'h0);
    @(negedge clk);
    expect_ctl("b2b.T5", 1'b0, 4'h1, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_ctl("b2b.T6", 1'b1, 4'h0, 8'h80, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    expect_ctl("b2b.T7", 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset asserted during LOAD_B aborts the instruction.
    inst = 16'h2C0A; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    expect_ctl("abort.T1", 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_ctl("abort.T2", 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    expect_ctl("abort.T3", 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_fields("abort.T3", 4'h0, 1'b0, 16'h0);
    @(negedge clk);
    expect_ctl("abort.T4", 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Wide instance: 20'hF200D gives rx=15, ry=2, sel=3, fmt=1.
    inst16 = 20'hF200D; inst_valid16 = 1'b1;
    @(negedge clk);
    inst_valid16 = 1'b0;
    check("w16.T1.mux_sel", 32'(mux_sel16), 32'h0F);
    check("w16.T1.S_enable", 32'(S_enable16), 32'd1);
    check("w16.T1.sel", 32'(sel16), 32'd3);
    @(negedge clk);
    check("w16.T2.mux_sel", 32'(mux_sel16), 32'(EXP_MUX16));
    check("w16.T2.C_enable", 32'(C_enable16), 32'd1);
    check("w16.T2.imm", 32'(imm16), 32'(EXP_IMM16));
    @(negedge clk);
    check("w16.T3.reg_enable", 32'(reg_enable16), 32'h8000);
    check("w16.T3.done", 32'(done16), 32'd1);
    check("w16.T3.mode", 32'(mode16), 32'd0);
    @(negedge clk);
    check("w16.T4.done", 32'(done16), 32'd0);
    check("w16.T4.ready", 32'(inst_ready16), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
